// File: rtl/mem_stage_wait_if.sv
// ----------------------------------------------------------------------------
// mem_stage_wait_if
// Bus between the pipeline (master) and the wait-state memory stage (slave).
//
// Signals:
//   MEM_R_EN  master->slave  read request, held while ready = 0
//   MEM_W_EN  master->slave  write request, held while ready = 0
//   ALU_Res   master->slave  32-bit byte address
//   Val_RM    master->slave  write data
//   Mem_out   slave->master  registered read data
//   ready     slave->master  1 = stage can advance this cycle
//   ADDR_ERR  slave->master  one-cycle pulse, completed access was out of range
// ----------------------------------------------------------------------------
interface mem_stage_wait_if #(
   parameter int DATA_W = 32
);
   logic              MEM_R_EN;
   logic              MEM_W_EN;
   logic [31:0]       ALU_Res;
   logic [DATA_W-1:0] Val_RM;
   logic [DATA_W-1:0] Mem_out;
   logic              ready;
   logic              ADDR_ERR;

   modport master (
      output MEM_R_EN,
      output MEM_W_EN,
      output ALU_Res,
      output Val_RM,
      input  Mem_out,
      input  ready,
      input  ADDR_ERR
   );

   modport slave (
      input  MEM_R_EN,
      input  MEM_W_EN,
      input  ALU_Res,
      input  Val_RM,
      output Mem_out,
      output ready,
      output ADDR_ERR
   );
endinterface : mem_stage_wait_if

// File: rtl/mem_stage_wait.sv
// ----------------------------------------------------------------------------
// mem_stage_wait
// Memory-access stage with a configurable number of wait states. A request
// seen while idle is latched, the stage stays busy for WAIT_CYCLES cycles,
// performs the word access on the last busy edge and then spends one DONE
// cycle presenting the result before returning to idle.
//
// Parameters:
//   DATA_W       data word width in bits (multiple of 8)
//   DEPTH        memory depth in words (power of two)
//   BASE_ADDR    byte address mapped to word 0
//   WAIT_CYCLES  busy cycles per access (>= 1)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of mem_stage_wait_if (request, address, data,
//         Mem_out, ready, ADDR_ERR)
// ----------------------------------------------------------------------------
module mem_stage_wait #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   mem_stage_wait_if.slave  bus
);

   // Number of low address bits that select a byte inside a word.
   localparam int BYTE_SH = (DATA_W > 8) ? $clog2(DATA_W / 8) : 0;
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [31:0]      BASE_W     = 32'(BASE_ADDR);
   localparam logic [31:0]      DEPTH_W    = 32'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   state_t              state_r;
   state_t              state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;

   logic                req_s;
   logic                start_s;
   logic                access_s;
   logic                mem_we_s;
   logic                ready_s;

   logic [31:0]         addr_off_s;
   logic [31:0]         word_idx_full_s;
   logic                below_base_s;
   logic                oor_s;

   logic                lat_wr_r;
   logic                lat_oor_r;
   logic [IDX_W-1:0]    lat_idx_r;
   logic [DATA_W-1:0]   lat_data_r;

   logic [DATA_W-1:0]   mem_out_r;
   logic                addr_err_r;

   // Storage powers up cleared and is deliberately left alone by rst.
   logic [DATA_W-1:0]   mem_r [DEPTH] = '{default: '0};

   // ------------------------------------------------------------------------
   // Request decode and address mapping
   // ------------------------------------------------------------------------

   // Decode the incoming address into a word index and range flag.
   always_comb begin
      req_s           = bus.MEM_R_EN | bus.MEM_W_EN;
      addr_off_s      = bus.ALU_Res - BASE_W;
      // Byte-offset bits are dropped: unaligned addresses hit the same word.
      word_idx_full_s = addr_off_s >> BYTE_SH;
      below_base_s    = (bus.ALU_Res < BASE_W);
      if (below_base_s) begin
         oor_s = 1'b1;
      end else if (word_idx_full_s >= DEPTH_W) begin
         oor_s = 1'b1;
      end else begin
         oor_s = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------

   // State and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state, counter update and handshake outputs.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      ready_s     = 1'b0;
      start_s     = 1'b0;
      access_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               start_s     = 1'b1;
               cnt_nxt_s   = CNT_LOAD;
               state_nxt_s = ST_BUSY;
               ready_s     = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
               ready_s     = 1'b1;
            end
         end
         ST_BUSY: begin
            ready_s = 1'b0;
            if (cnt_r != CNT_ZERO) begin
               cnt_nxt_s   = cnt_r - CNT_ONE;
               state_nxt_s = ST_BUSY;
            end else begin
               // Last busy cycle: the memory access happens on this edge.
               access_s    = 1'b1;
               state_nxt_s = ST_DONE;
            end
         end
         ST_DONE: begin
            // Unconditional return so the held request is never re-issued.
            ready_s     = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            ready_s     = 1'b0;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request latch
   // ------------------------------------------------------------------------

   // Capture type, index, data and range on acceptance; held until next start.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_wr_r   <= 1'b0;
         lat_oor_r  <= 1'b0;
         lat_idx_r  <= {IDX_W{1'b0}};
         lat_data_r <= DATA_ZERO;
      end else if (start_s) begin
         // A simultaneous read+write is treated as a write.
         lat_wr_r   <= bus.MEM_W_EN;
         lat_oor_r  <= oor_s;
         lat_idx_r  <= word_idx_full_s[IDX_W-1:0];
         lat_data_r <= bus.Val_RM;
      end else begin
         lat_wr_r   <= lat_wr_r;
         lat_oor_r  <= lat_oor_r;
         lat_idx_r  <= lat_idx_r;
         lat_data_r <= lat_data_r;
      end
   end

   // ------------------------------------------------------------------------
   // Memory array and result registers
   // ------------------------------------------------------------------------

   // Writes to out-of-range addresses are dropped; rst also blocks the write.
   always_comb begin
      if (rst) begin
         mem_we_s = 1'b0;
      end else begin
         mem_we_s = access_s & lat_wr_r & ~lat_oor_r;
      end
   end

   // Word write port.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[lat_idx_r] <= lat_data_r;
      end
   end

   // Read data register: loads on completed reads, zero for out-of-range.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_out_r <= DATA_ZERO;
      end else if (access_s && !lat_wr_r) begin
         if (lat_oor_r) begin
            mem_out_r <= DATA_ZERO;
         end else begin
            mem_out_r <= mem_r[lat_idx_r];
         end
      end else begin
         mem_out_r <= mem_out_r;
      end
   end

   // Range error pulse, high only during the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err_r <= 1'b0;
      end else begin
         addr_err_r <= access_s & lat_oor_r;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------

   // Drive the bus outputs.
   always_comb begin
      bus.Mem_out  = mem_out_r;
      bus.ready    = ready_s;
      bus.ADDR_ERR = addr_err_r;
   end

endmodule : mem_stage_wait

// File: tb/tb_mem_stage_wait.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_wait
// Directed bench for mem_stage_wait with default parameters
// (DATA_W 32, DEPTH 64, BASE_ADDR 1024, WAIT_CYCLES 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_mem_stage_wait;

   localparam int DATA_W      = 32;
   localparam int DEPTH       = 64;
   localparam int BASE_ADDR   = 1024;
   localparam int WAIT_CYCLES = 4;
   localparam int PERIOD      = 10;

   logic clk;
   logic rst;

   int n_cmp;
   int n_bad;
   time last_done_t;

   mem_stage_wait_if #(.DATA_W(DATA_W)) bus ();

   mem_stage_wait #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .BASE_ADDR   (BASE_ADDR),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #(PERIOD / 2) clk = ~clk;
   end

   // Single comparison point: counts and reports mismatches.
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete access: drive request, count ready-low cycles (bounded),
   // check the DONE cycle, then drop the request just after the DONE edge.
   task automatic do_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic chk_out, input logic [31:0] exp_out,
                            input logic exp_err);
      int n;
      bus.MEM_R_EN = rd;
      bus.MEM_W_EN = wr;
      bus.ALU_Res  = addr;
      bus.Val_RM   = data;
      n = 0;
      @(negedge clk);
      while (!bus.ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      check_val({tag, " busy"}, 64'(n), 64'(WAIT_CYCLES + 1));
      last_done_t = $time;
      check_val({tag, " err"}, 64'(bus.ADDR_ERR), 64'(exp_err));
      if (chk_out) begin
         check_val({tag, " out"}, 64'(bus.Mem_out), 64'(exp_out));
      end
      @(posedge clk);
      #1;
      bus.MEM_R_EN = 1'b0;
      bus.MEM_W_EN = 1'b0;
   endtask

   initial begin
      time t1;
      n_cmp        = 0;
      n_bad        = 0;
      last_done_t  = 0;
      rst          = 1'b1;
      bus.MEM_R_EN = 1'b0;
      bus.MEM_W_EN = 1'b0;
      bus.ALU_Res  = 32'd0;
      bus.Val_RM   = 32'd0;

      // Reset, then 10 idle cycles with ready held high.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("idle ready", 64'(bus.ready), 64'd1);
      end
      check_val("rst out", 64'(bus.Mem_out), 64'd0);
      check_val("rst err", 64'(bus.ADDR_ERR), 64'd0);
      @(posedge clk);
      #1;

      // Write then read back, including an unaligned read of the same word.
      do_access("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
      do_access("rd1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      do_access("rd1030", 1'b1, 1'b0, 32'd1030, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

      // Read and write together: a write, Mem_out keeps the previous read.
      do_access("rw1032", 1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0);
      do_access("rd1032", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 32'h12345678, 1'b0);

      // Out-of-range reads below base and past the end.
      do_access("rd1000", 1'b1, 1'b0, 32'd1000, 32'h0, 1'b1, 32'h0, 1'b1);
      @(negedge clk);
      check_val("err pulse end", 64'(bus.ADDR_ERR), 64'd0);
      @(posedge clk);
      #1;
      do_access("rdhigh", 1'b1, 1'b0, 32'(BASE_ADDR + 4 * DEPTH), 32'h0, 1'b1, 32'h0, 1'b1);

      // Out-of-range write must not disturb any stored word.
      do_access("wr1000", 1'b0, 1'b1, 32'd1000, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
      do_access("chk1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 32'h0, 1'b0);
      do_access("chk1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      do_access("chk1032", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 32'h12345678, 1'b0);

      // Write to 1036 aborted by rst in the second busy cycle.
      bus.MEM_W_EN = 1'b1;
      bus.ALU_Res  = 32'd1036;
      bus.Val_RM   = 32'hAAAA5555;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("abort busy ready", 64'(bus.ready), 64'd0);
      rst          = 1'b1;
      bus.MEM_W_EN = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("abort idle ready", 64'(bus.ready), 64'd1);
      check_val("abort out", 64'(bus.Mem_out), 64'd0);
      check_val("abort err", 64'(bus.ADDR_ERR), 64'd0);
      @(posedge clk);
      #1;
      do_access("rd1036", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 32'h0, 1'b0);

      // Back-to-back reads of prestored words.
      do_access("pre1024", 1'b0, 1'b1, 32'd1024, 32'd1, 1'b0, 32'h0, 1'b0);
      do_access("pre1028", 1'b0, 1'b1, 32'd1028, 32'd2, 1'b0, 32'h0, 1'b0);
      do_access("b2b1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 32'd1, 1'b0);
      t1 = last_done_t;
      do_access("b2b1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 32'd2, 1'b0);
      check_val("b2b gap", 64'(last_done_t - t1), 64'(6 * PERIOD));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mem_stage_wait

// File: doc/mem_stage_wait.md
# mem_stage_wait

Parametrised memory-access stage of the pipelined ARM core: takes the execute-stage result as a byte address, performs a word read or write on an internal data memory with a configurable access latency, and drives a `ready` signal the hazard/freeze logic uses to stall the pipeline until the access completes. It extends the single-cycle memory stage with configurable width, depth, base address and wait states, plus out-of-range detection.

## Interface
- `DATA_W`, 32, data word width in bits; must be a multiple of 8.
- `DEPTH`, 64, memory depth in words; must be a power of two.
- `BASE_ADDR`, 1024, byte address that maps to word 0.
- `WAIT_CYCLES`, 4, number of busy cycles per access; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MEM_R_EN`  in  1  read request; held stable by the pipeline while `ready` = 0.
- `MEM_W_EN`  in  1  write request; held stable while `ready` = 0.
- `ALU_Res`  in  32  byte address.
- `Val_RM`  in  DATA_W  write data.
- `Mem_out`  out  DATA_W  registered read data.
- `ready`  out  1  combinational; 1 = stage can advance this cycle.
- `ADDR_ERR`  out  1  registered one-cycle pulse: the completed access was out of range.

## Operation
- Word index = (`ALU_Res` − `BASE_ADDR`) >> log2(DATA_W/8). Low byte-offset bits are ignored: no alignment fault.
- Out of range means `ALU_Res` < `BASE_ADDR` or index ≥ `DEPTH`. On an out-of-range access:
  - a write is dropped;
  - a read loads 0 into `Mem_out`;
  - `ADDR_ERR` pulses in the DONE cycle.
- Request `req` = `MEM_R_EN` | `MEM_W_EN`. If both are set, the access is a write, `Mem_out` is unchanged, and no read is performed.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `req` = 0: stay in IDLE; `ready` = 1.
  - IDLE, `req` = 1: latch address, data and type; load `cnt` = WAIT_CYCLES−1; go to BUSY; `ready` = 0.
  - BUSY: `ready` = 0. If `cnt` ≠ 0, decrement `cnt`. If `cnt` = 0, perform the access on this edge (memory write, or `Mem_out` ← mem[index]) and go to DONE.
  - DONE: `ready` = 1 and `ADDR_ERR` is valid. Next state is unconditionally IDLE, so the pipeline advances on this edge and the same request is never re-issued.
- The stage uses the latched request. Input changes during BUSY or DONE are ignored.
- `Mem_out` holds its value until the next completed read (or out-of-range read).
- Memory contents initialise to 0 and are not cleared by `rst`.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `Mem_out` = 0, `ADDR_ERR` = 0. After reset, `ready` = ~`req`.
- No request: zero latency; `ready` stays high continuously.
- Any access where `req` first rises at cycle T:
  - `ready` = 0 for cycles T … T+WAIT_CYCLES;
  - cycle T+WAIT_CYCLES+1 is DONE: `ready` = 1, `Mem_out` holds the new read data, `ADDR_ERR` is valid;
  - total occupancy is WAIT_CYCLES+2 cycles.
- Back-to-back requests: a new request seen in the IDLE cycle after DONE starts immediately, giving a one-cycle `ready` bubble-free handoff. The only gap is the single DONE cycle.
- `rst` mid-access (BUSY or DONE) aborts the access:
  - a pending write is not performed;
  - `Mem_out` and `ADDR_ERR` go to 0;
  - the state returns to IDLE on that edge.
- Write data is visible to a read issued in the next request.

## Test plan
- Reset, then drive no request for 10 cycles. Required: `ready` = 1 every cycle, `Mem_out` = 0, `ADDR_ERR` = 0.
- Write 0xDEADBEEF to address 1028, then read 1028 with WAIT_CYCLES = 4. Required:
  - `ready` = 0 for 5 cycles on each access;
  - the read's DONE cycle shows `Mem_out` = 0xDEADBEEF;
  - a read of 1030 also returns 0xDEADBEEF (offset ignored).
- Read address 1000 and read address 1024 + 4·DEPTH. Required: `Mem_out` = 0 and an `ADDR_ERR` pulse in DONE. A write to 1000 leaves all words unchanged.
- Issue `MEM_R_EN` and `MEM_W_EN` together with data 0x12345678 at 1032. Required: `Mem_out` is unchanged, and a later read of 1032 returns 0x12345678.
- Write 0xAAAA5555 to 1036 and assert `rst` during the second BUSY cycle. Required:
  - the state is IDLE the next cycle, with `Mem_out` = 0;
  - a subsequent read of 1036 returns 0.
- Drive back-to-back reads of 1024 and 1028 with prestored values 1 and 2. Required: DONE cycles 6 cycles apart, showing `Mem_out` = 1 then 2.
